// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring radix-2 divider sequencer for DIV/DIVU in the execute stage.
// Stalls EX while busy and returns {remainder, quotient} for the HI/LO write.
module div_seq_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stall_o
);

    typedef enum logic [1:0] {StIdle, StDivZero, StOn, StEnd} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W:0]     part_q, part_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  a_neg, b_neg;
    logic [DATA_W-1:0]     abs_a, abs_b;
    logic [2*DATA_W:0]     shifted, part_next;
    logic [DATA_W:0]       diff;
    logic [DATA_W-1:0]     quo_fix, rem_fix;

    // Magnitudes; the most negative value negates to itself and is read as unsigned.
    assign a_neg = signed_i & opdata1_i[DATA_W-1];
    assign b_neg = signed_i & opdata2_i[DATA_W-1];
    assign abs_a = a_neg ? -opdata1_i : opdata1_i;
    assign abs_b = b_neg ? -opdata2_i : opdata2_i;

    // One restoring iteration: shift, trial subtract from upper half, set quotient bit.
    assign shifted   = part_q << 1;
    assign diff      = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_q};
    assign part_next = diff[DATA_W] ? shifted
                                    : {diff, shifted[DATA_W-1:1], 1'b1};

    assign quo_fix = neg_quo_q ? -part_next[DATA_W-1:0] : part_next[DATA_W-1:0];
    assign rem_fix = neg_rem_q ? -part_next[2*DATA_W-1:DATA_W]
                               : part_next[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        unique case (state_q)
            StIdle: begin
                ready_d = 1'b0;
                if (start_i && !annul_i) begin
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    divisor_d = abs_b;
                    part_d    = {{(DATA_W+1){1'b0}}, abs_a};
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? StDivZero : StOn;
                end
            end
            StDivZero: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = StEnd;
                end
            end
            StOn: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    part_d = part_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // Last iteration: sign fix-up lands in the result on entry to END.
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d  = StEnd;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            StEnd: begin
                if (annul_i || !start_i) begin
                    state_d  = StIdle;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            part_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign stall_o  = start_i & ~ready_q & ~annul_i;

endmodule
